// File: rtl/capture_buffer.sv
// Circular sample capture memory: records pre/post-trigger samples after arming,
// then replays the stored window oldest-first to a UART, one byte per sample.
module capture_buffer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    run,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  input  logic [15:0]             delay_count,
  input  logic [15:0]             read_count,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    triggered,
  output logic                    done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, ARMED, POST, RD_SETUP, RD_FETCH, RD_SEND, WAIT_HI, WAIT_LO, DONE
  } state_t;

  state_t                  state_r;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] rd_data_r;
  logic [ADDR_WIDTH-1:0]   wr_ptr_r;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r;
  logic [CW-1:0]           fill_r;
  logic [CW-1:0]           n_r;
  logic [CW-1:0]           n_sel_s;
  logic [15:0]             post_cnt_r;
  logic                    wr_en_s;

  // Write qualifier: samples land only while armed or still collecting post-trigger data.
  always_comb begin
    wr_en_s = 1'b0;
    case (state_r)
      ARMED:   wr_en_s = valid_in;
      POST:    wr_en_s = valid_in && (post_cnt_r != 16'd0);
      default: wr_en_s = 1'b0;
    endcase
  end

  // Readout length: requested count clamped to what the buffer actually holds.
  always_comb begin
    if (32'(read_count) < 32'(fill_r)) begin
      n_sel_s = CW'(read_count);
    end else begin
      n_sel_s = fill_r;
    end
  end

  // Sample RAM with registered read port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= data_in;
    end
    rd_data_r <= mem[rd_ptr_r];
  end

  // Capture/readout sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fill_r     <= '0;
      n_r        <= '0;
      post_cnt_r <= 16'd0;
      tx_data    <= 8'd0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
        if (fill_r != CW'(DEPTH)) begin
          fill_r <= fill_r + CW'(1);
        end
      end
      case (state_r)
        IDLE: begin
          if (arm) begin
            wr_ptr_r  <= '0;
            fill_r    <= '0;
            triggered <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ARMED;
          end
        end
        ARMED: begin
          // The sample presented alongside run is the last pre-trigger sample.
          if (run) begin
            triggered  <= 1'b1;
            post_cnt_r <= delay_count;
            state_r    <= POST;
          end
        end
        POST: begin
          if (post_cnt_r == 16'd0) begin
            state_r <= RD_SETUP;
          end else if (valid_in) begin
            post_cnt_r <= post_cnt_r - 16'd1;
          end
        end
        RD_SETUP: begin
          n_r      <= n_sel_s;
          rd_ptr_r <= wr_ptr_r - n_sel_s[ADDR_WIDTH-1:0];
          state_r  <= (n_sel_s == CW'(0)) ? DONE : RD_FETCH;
        end
        RD_FETCH: begin
          state_r <= RD_SEND;
        end
        RD_SEND: begin
          tx_data  <= 8'(rd_data_r);
          tx_start <= 1'b1;
          state_r  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state_r <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            n_r      <= n_r - CW'(1);
            rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            state_r  <= (n_r == CW'(1)) ? DONE : RD_FETCH;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/capture_buffer.md
# capture_buffer

Sample capture memory between the sampler/trigger and the UART transmitter. After arming, it continuously writes valid samples into a circular RAM. On trigger it records a programmed number of post-trigger samples, then streams the stored window, oldest first, to the UART one byte per sample. It replaces the direct sampler-to-UART data path; the transmit mux selects it in data mode.

## Interface
- SAMPLE_WIDTH, 8, sample width in bits; must be ≤ 8, zero-extended onto tx_data.
- ADDR_WIDTH, 10, RAM address width; DEPTH = 2**ADDR_WIDTH samples.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle start pulse; honoured only in IDLE.
- run  in  1  trigger from trigger stage; honoured only in ARMED.
- data_in  in  SAMPLE_WIDTH  sample from sampler.
- valid_in  in  1  data_in qualifier.
- delay_count  in  16  post-trigger samples to record.
- read_count  in  16  samples requested for readout.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to UART; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle transmit request.
- busy  out  1  high whenever state ≠ IDLE.
- triggered  out  1  set on trigger acceptance; cleared on next accepted arm.
- done  out  1  one-cycle pulse when readout completes.

## Operation
- Reset: state IDLE; wr_ptr = 0, fill = 0, all counters 0; tx_data, tx_start, busy, triggered, done all 0. RAM contents are not reset.
- IDLE, arm=1: clear wr_ptr, fill, triggered; go to ARMED.
- ARMED: each valid_in writes data_in at wr_ptr; wr_ptr increments mod DEPTH; fill increments, saturating at DEPTH.
  - run=1: that cycle's valid sample is written as the last pre-trigger sample.
  - Same cycle: set triggered, load post_cnt = delay_count, go to POST.
- POST: if post_cnt = 0, go to RD_SETUP without writing. Otherwise each valid sample is written as in ARMED and decrements post_cnt.
- RD_SETUP:
  - n = min(read_count, fill); fill ≤ DEPTH, so n ≤ DEPTH.
  - rd_ptr = (wr_ptr − n) mod DEPTH.
  - If n = 0, go to DONE; otherwise go to RD_FETCH.
- RD_FETCH: issue synchronous RAM read at rd_ptr (1-cycle latency); go to RD_SEND.
- RD_SEND: latch RAM output into tx_data; pulse tx_start; go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0. Then decrement n and increment rd_ptr mod DEPTH.
  - If n reaches 0, go to DONE; else go to RD_FETCH.
- DONE: pulse done; go to IDLE.
- Ignored inputs:
  - arm outside IDLE.
  - run outside ARMED.
  - valid_in outside ARMED/POST.
  - Changes to delay_count/read_count after they are sampled (POST entry / RD_SETUP).
- Reset in any state returns to IDLE on the next edge. A readout in progress is abandoned; no further tx_start is issued.

## Timing
- Write: sample valid at edge k is in RAM after edge k.
- Trigger to POST: 1 cycle. Last post-trigger write to RD_SETUP: 1 cycle.
- First tx_start: 3 cycles after RD_SETUP entry (RD_SETUP → RD_FETCH → RD_SEND).
- tx_start is high exactly one cycle per byte. It never reasserts until tx_busy has been observed high and then low.
- Per-byte overhead beyond UART time: 3 cycles (WAIT_LO exit → RD_FETCH → RD_SEND).
- Address arithmetic is modulo DEPTH (natural ADDR_WIDTH overflow). fill and post_cnt never wrap.
- Bytes sent = min(read_count, fill), in ascending write order ending with the newest sample.

## Test plan
- ARMED→POST→readout, DEPTH=1024:
  - Stimulus: arm; valid samples 0,1,2,…; run while sample 9 is presented; delay_count=5; read_count=10; UART model busy 8 cycles per byte.
  - Required: tx_data sequence 5..14; triggered=1; done pulses once after byte 14; busy=0 afterwards.
- Wrap/clamp, ADDR_WIDTH=4:
  - Stimulus: 40 pre-trigger samples (values 0..39, run at 39); delay_count=4; read_count=100.
  - Required: exactly 16 bytes, values 28..43.
- delay_count=0, read_count=3, run at sample 7:
  - Required: bytes 5,6,7; no sample after 7 is written.
- Handshake:
  - Stimulus: tx_busy held high 50 cycles after a tx_start.
  - Required: no second tx_start; tx_data unchanged until tx_busy falls.
  - Also: tx_busy never rising stalls in WAIT_HI with busy=1.
- Reset mid-readout:
  - Stimulus: reset during byte 3 of 10.
  - Required: all outputs 0 next cycle. A fresh arm/run capture works normally, and arm pulses during ARMED/POST are ignored.
- Degenerate cases:
  - read_count=0: done pulses with zero tx_start.
  - run in IDLE: no state change.
  - Arm then immediate run with no valid samples: fill=0, so done pulses with no bytes sent.
